// File: rtl/forwarding_hazard_unit.sv
// Operand-forwarding select, load-use stall and redirect flush for the ID/EX boundary.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.

module fhu_operand_sel #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      uses,
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic                      ex_valid,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      mem_valid,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic [1:0]                sel,
  output logic                      load_use
);
  localparam logic [1:0] FORWARD_NONE     = 2'd0;
  localparam logic [1:0] FORWARD_FROM_EX  = 2'd1;
  localparam logic [1:0] FORWARD_FROM_MEM = 2'd2;

  logic ex_hit, mem_hit;

  // x0 is hardwired, so a write to it never produces a forward or a hazard
  assign ex_hit   = uses && (rs != '0) && ex_valid && ex_reg_write && (ex_rd == rs);
  assign mem_hit  = uses && (rs != '0) && mem_valid && mem_reg_write && (mem_rd == rs);
  assign load_use = ex_hit && ex_mem_read;

  always_comb begin
    sel = FORWARD_NONE;
    if (ex_hit && !ex_mem_read) sel = FORWARD_FROM_EX;
    else if (mem_hit)           sel = FORWARD_FROM_MEM;
  end
endmodule

module forwarding_hazard_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      ex_pc_src,
  input  logic                      ex_jalr_flag,
  input  logic                      hold,
  output logic [1:0]                forward_rs1,
  output logic [1:0]                forward_rs2,
  output logic                      stall,
  output logic                      flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
`endif
);
  localparam int         NUM_OPS      = 2;
  localparam logic [1:0] FORWARD_NONE = 2'd0;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
  } ex_slot_t;

  // Load data is available from WB, so the MEM slot needs no load flag
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
  } mem_slot_t;

  ex_slot_t                              ex_slot;
  mem_slot_t                             mem_slot;
  logic [NUM_OPS-1:0][REG_ADDR_WIDTH-1:0] rs_vec;
  logic [NUM_OPS-1:0]                    uses_vec, lu_vec;
  logic [NUM_OPS-1:0][1:0]               sel_vec;
  logic                                  bubble;

  assign rs_vec   = {id_rs2, id_rs1};
  assign uses_vec = {id_uses_rs2, id_uses_rs1};

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      fhu_operand_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_sel (
        .uses          (uses_vec[g]),
        .rs            (rs_vec[g]),
        .ex_valid      (ex_slot.valid),
        .ex_reg_write  (ex_slot.reg_write),
        .ex_mem_read   (ex_slot.mem_read),
        .ex_rd         (ex_slot.rd),
        .mem_valid     (mem_slot.valid),
        .mem_reg_write (mem_slot.reg_write),
        .mem_rd        (mem_slot.rd),
        .sel           (sel_vec[g]),
        .load_use      (lu_vec[g])
      );
    end
  endgenerate

  assign flush  = ex_pc_src || ex_jalr_flag;
  assign stall  = id_valid && !flush && (|lu_vec);
  assign bubble = flush || stall || !id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_slot     <= '0;
      mem_slot    <= '0;
      forward_rs1 <= FORWARD_NONE;
      forward_rs2 <= FORWARD_NONE;
    end else if (!hold) begin
      mem_slot <= '{valid: ex_slot.valid, rd: ex_slot.rd, reg_write: ex_slot.reg_write};
      if (bubble) begin
        ex_slot     <= '0;
        forward_rs1 <= FORWARD_NONE;
        forward_rs2 <= FORWARD_NONE;
      end else begin
        ex_slot     <= '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
        forward_rs1 <= sel_vec[0];
        forward_rs2 <= sel_vec[1];
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (!hold) begin
      if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: pipeline-occupancy model plus hand-computed checkpoints.
`timescale 1ns/1ps
module tb_forwarding_hazard_unit;
  localparam int NONE = 0, FEX = 1, FMEM = 2;

  logic clk = 0, reset = 1;
  logic id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_reg_write = 0, id_mem_read = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic ex_pc_src = 0, ex_jalr_flag = 0, hold = 0;
  logic [1:0] forward_rs1, forward_rs2;
  logic stall, flush;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count, flush_count;
`endif

  forwarding_hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_pc_src(ex_pc_src),
    .ex_jalr_flag(ex_jalr_flag), .hold(hold), .forward_rs1(forward_rs1),
    .forward_rs2(forward_rs2), .stall(stall), .flush(flush)
`ifdef HAZARD_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the instructions occupying EX (age 0) and MEM (age 1)
  typedef struct {bit v; int rd; bit rw; bit mr;} rec_t;
  rec_t pipe[2];
  int   m_f1, m_f2;
  longint m_sc, m_fc;

  function automatic int sel(int rs, bit uses);
    if (!uses || rs == 0) return NONE;
    for (int a = 0; a < 2; a++) begin
      if (pipe[a].v && pipe[a].rw && pipe[a].rd == rs) begin
        if (a == 0 && pipe[a].mr) continue;
        return (a == 0) ? FEX : FMEM;
      end
    end
    return NONE;
  endfunction

  function automatic bit load_hazard(int rs, bit uses);
    return uses && rs != 0 && pipe[0].v && pipe[0].rw && pipe[0].mr && pipe[0].rd == rs;
  endfunction

  function automatic bit exp_flush();
    return ex_pc_src || ex_jalr_flag;
  endfunction

  function automatic bit exp_stall();
    return id_valid && !exp_flush() &&
           (load_hazard(int'(id_rs1), id_uses_rs1) || load_hazard(int'(id_rs2), id_uses_rs2));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe[0] <= '{0, 0, 0, 0};
      pipe[1] <= '{0, 0, 0, 0};
      m_f1 <= NONE; m_f2 <= NONE; m_sc <= 0; m_fc <= 0;
    end else if (!hold) begin
      pipe[1] <= pipe[0];
      if (exp_flush() || exp_stall() || !id_valid) begin
        pipe[0] <= '{0, 0, 0, 0};
        m_f1 <= NONE; m_f2 <= NONE;
      end else begin
        pipe[0] <= '{1, int'(id_rd), id_reg_write, id_mem_read};
        m_f1 <= sel(int'(id_rs1), id_uses_rs1);
        m_f2 <= sel(int'(id_rs2), id_uses_rs2);
      end
      if (exp_stall()) m_sc <= m_sc + 1;
      if (exp_flush()) m_fc <= m_fc + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cmp_fwd1", forward_rs1, m_f1);
      chk("cmp_fwd2", forward_rs2, m_f2);
      chk("cmp_stall", stall, exp_stall());
      chk("cmp_flush", flush, exp_flush());
`ifdef HAZARD_PERF_EN
      chk("cmp_stall_cnt", stall_count, m_sc);
      chk("cmp_flush_cnt", flush_count, m_fc);
`endif
    end
  end

  // One ID cycle: drive just after the edge, return at the following negedge
  task automatic cyc(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit rw, input bit mr,
                     input bit pc = 0, input bit jalr = 0, input bit hld = 0);
    @(posedge clk); #1;
    id_valid = v; id_rs1 = 5'(rs1); id_uses_rs1 = u1; id_rs2 = 5'(rs2); id_uses_rs2 = u2;
    id_rd = 5'(rd); id_reg_write = rw; id_mem_read = mr;
    ex_pc_src = pc; ex_jalr_flag = jalr; hold = hld;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2;
    chk("reset_fwd1", forward_rs1, NONE);
    chk("reset_fwd2", forward_rs2, NONE);
    chk("reset_stall", stall, 0);
    chk("reset_flush", flush, 0);
    #10 reset = 0;

    // Case 1: add x5; sub reads x5 (rs2=x5 but unused)
    cyc(1, 0, 0, 0, 0, 5, 1, 0);
    cyc(1, 5, 1, 5, 0, 8, 1, 0);
    chk("c1_stall", stall, 0);
    idle();
    chk("c1_fwd1_ex", forward_rs1, FEX);
    chk("c1_fwd2_none", forward_rs2, NONE);

    // Case 2: add x5, nop, or reads rs2=x5; then x0 producer
    cyc(1, 0, 0, 0, 0, 5, 1, 0);
    idle();
    cyc(1, 1, 1, 5, 1, 10, 1, 0);
    idle();
    chk("c2_fwd1_none", forward_rs1, NONE);
    chk("c2_fwd2_mem", forward_rs2, FMEM);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 11, 1, 0);
    idle();
    chk("c2_x0_fwd1", forward_rs1, NONE);
    chk("c2_x0_fwd2", forward_rs2, NONE);

    // Case 3: lw x7; add reads x7 -> one stall cycle then MEM forward
    cyc(1, 0, 0, 0, 0, 7, 1, 1);
    cyc(1, 7, 1, 0, 0, 9, 1, 0);
    chk("c3_stall_on", stall, 1);
    cyc(1, 7, 1, 0, 0, 9, 1, 0);
    chk("c3_stall_off", stall, 0);
    chk("c3_bubble_fwd1", forward_rs1, NONE);
    idle();
    chk("c3_fwd1_mem", forward_rs1, FMEM);
    chk("c3_fwd2_none", forward_rs2, NONE);
`ifdef HAZARD_PERF_EN
    chk("c3_stall_count", stall_count, 1);
`endif

    // Case 4: lw x7 in EX, dependent in ID with taken branch -> flush wins
    cyc(1, 0, 0, 0, 0, 7, 1, 1);
    cyc(1, 7, 1, 0, 0, 9, 1, 0, 1);
    chk("c4_flush", flush, 1);
    chk("c4_stall", stall, 0);
    cyc(1, 7, 1, 0, 0, 12, 1, 0);
    chk("c4_ex_empty_stall", stall, 0);
    chk("c4_fwd1_none", forward_rs1, NONE);
    chk("c4_fwd2_none", forward_rs2, NONE);
    idle();
    chk("c4_fwd1_mem", forward_rs1, FMEM);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("c4_jalr_flush", flush, 1);
    idle();
`ifdef HAZARD_PERF_EN
    chk("c4_flush_count", flush_count, 2);
    chk("c4_stall_count", stall_count, 1);
`endif

    // Case 5: freeze with sub (x8) in EX and add (x5) in MEM
    cyc(1, 0, 0, 0, 0, 5, 1, 0);
    cyc(1, 5, 1, 0, 0, 8, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8, 1, 5, 1, 13, 1, 0, 0, 0, 1);
      chk("c5_hold_fwd1", forward_rs1, FEX);
      chk("c5_hold_fwd2", forward_rs2, NONE);
    end
    cyc(1, 8, 1, 5, 1, 13, 1, 0);
    chk("c5_last_hold_fwd1", forward_rs1, FEX);
    idle();
    chk("c5_after_fwd1", forward_rs1, FEX);
    chk("c5_after_fwd2", forward_rs2, FMEM);

    // Back-to-back producers of x5: youngest wins
    cyc(1, 0, 0, 0, 0, 5, 1, 0);
    cyc(1, 0, 0, 0, 0, 5, 1, 0);
    cyc(1, 5, 1, 0, 0, 14, 1, 0);
    idle();
    chk("b2b_fwd1_ex", forward_rs1, FEX);

    // Case 6: reset with both slots valid and a stall pending
    cyc(1, 0, 0, 0, 0, 3, 1, 0);
    cyc(1, 3, 1, 0, 0, 4, 1, 1);
    cyc(1, 4, 1, 3, 1, 15, 1, 0);
    chk("c6_pre_stall", stall, 1);
    chk("c6_pre_fwd1", forward_rs1, FEX);
    #2 reset = 1;
    #1;
    chk("c6_rst_fwd1", forward_rs1, NONE);
    chk("c6_rst_fwd2", forward_rs2, NONE);
    chk("c6_rst_stall", stall, 0);
`ifdef HAZARD_PERF_EN
    chk("c6_rst_stall_count", stall_count, 0);
    chk("c6_rst_flush_count", flush_count, 0);
`endif
    @(posedge clk); #1;
    reset = 0;
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
